// File: rtl/mem_rw_arbiter_pkg.sv
// Shared encodings and widths for the DDR read/write burst arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_WR = 1'b0,
    OWNER_RD = 1'b1
  } owner_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 4096;
  localparam int unsigned WDOG_WIDTH         = 16;
  localparam int unsigned LEN_WIDTH          = 8;
  localparam int unsigned LINE_WIDTH         = 18;

endpackage

// File: rtl/mem_rw_arbiter_if.sv
// DDR-engine side of the arbiter: burst command, write-data and read-data strobes.
interface mem_rw_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 30,
  parameter int unsigned MEM_DATA_BITS = 256
);

  logic                     mem_req;
  logic                     mem_rw;
  logic [LEN_WIDTH-1:0]     mem_len;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic                     mem_wr_data_rd;
  logic [MEM_DATA_BITS-1:0] mem_wr_data;
  logic [MEM_DATA_BITS-1:0] mem_rd_data;
  logic                     mem_rd_data_vld;
  logic                     mem_finish;

  modport master (
    output mem_req, mem_rw, mem_len, mem_addr, mem_wr_data,
    input  mem_wr_data_rd, mem_rd_data, mem_rd_data_vld, mem_finish
  );

  modport slave (
    input  mem_req, mem_rw, mem_len, mem_addr, mem_wr_data,
    output mem_wr_data_rd, mem_rd_data, mem_rd_data_vld, mem_finish
  );

endinterface

// File: rtl/mem_rw_arbiter.sv
// Round-robin arbiter sharing one DDR burst engine between a write path and a read path,
// with a grant-to-finish watchdog. Engine-side ports mirror mem_rw_arbiter_if signal-for-signal.
module mem_rw_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 30,
  parameter int unsigned MEM_DATA_BITS  = 256,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                     ddr_clk_i,
  input  logic                     ddr_rst_n_i,
  input  logic                     wr_ddr_req_i,
  input  logic [LEN_WIDTH-1:0]     wr_ddr_len_i,
  input  logic [ADDR_WIDTH-1:0]    wr_ddr_addr_i,
  input  logic [MEM_DATA_BITS-1:0] wr_ddr_data_i,
  output logic                     ddr_fifo_rd_req_o,
  output logic                     wr_ddr_finish_o,
  input  logic                     rd_ddr_req_i,
  input  logic [LEN_WIDTH-1:0]     rd_ddr_len_i,
  input  logic [ADDR_WIDTH-1:0]    rd_ddr_addr_i,
  output logic [MEM_DATA_BITS-1:0] rd_ddr_data_o,
  output logic                     rd_ddr_data_vld_o,
  output logic                     rd_ddr_finish_o,
  input  logic [LINE_WIDTH-1:0]    wr_burst_line_i,
  input  logic [LINE_WIDTH-1:0]    rd_burst_line_i,
  output logic                     mem_req_o,
  output logic                     mem_rw_o,
  output logic [LEN_WIDTH-1:0]     mem_len_o,
  output logic [ADDR_WIDTH-1:0]    mem_addr_o,
  input  logic                     mem_wr_data_rd_i,
  output logic [MEM_DATA_BITS-1:0] mem_wr_data_o,
  input  logic [MEM_DATA_BITS-1:0] mem_rd_data_i,
  input  logic                     mem_rd_data_vld_i,
  input  logic                     mem_finish_i,
  output logic                     arb_err_o
);

  localparam logic [WDOG_WIDTH-1:0] WDOG_LIMIT = WDOG_WIDTH'(TIMEOUT_CYCLES - 1);

  arb_state_e              state_q, state_d;
  owner_e                  owner_q, owner_d;
  owner_e                  last_owner_q, last_owner_d;
  logic                    mem_req_q, mem_req_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WDOG_WIDTH-1:0]   wdog_q, wdog_d;
  logic                    err_q, err_d;

  logic   active;
  logic   wr_elig;
  logic   rd_elig;
  logic   engine_strobe;
  logic   timeout;
  owner_e grant_owner;

  assign active        = (state_q == ST_GRANT) || (state_q == ST_BUSY);
  assign wr_elig       = wr_ddr_req_i;
  // Equal line counters mean the read side has nothing to fetch, wrap included.
  assign rd_elig       = rd_ddr_req_i && (rd_burst_line_i != wr_burst_line_i);
  assign engine_strobe = mem_wr_data_rd_i || mem_rd_data_vld_i || mem_finish_i;

  always_comb begin
    wdog_d = '0;
    if (active) begin
      wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
    end
  end

  // Fires on the edge the counter lands on the limit, so the error is visible that cycle.
  assign timeout = active && (wdog_d == WDOG_LIMIT);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    mem_req_d    = mem_req_q;
    len_d        = len_q;
    addr_d       = addr_q;
    err_d        = err_q;
    grant_owner  = OWNER_WR;

    if (wr_elig && rd_elig) begin
      grant_owner = (last_owner_q == OWNER_RD) ? OWNER_WR : OWNER_RD;
    end else if (rd_elig) begin
      grant_owner = OWNER_RD;
    end

    unique case (state_q)
      ST_IDLE: begin
        mem_req_d = 1'b0;
        if (wr_elig || rd_elig) begin
          state_d      = ST_GRANT;
          owner_d      = grant_owner;
          last_owner_d = grant_owner;
          mem_req_d    = 1'b1;
          len_d        = (grant_owner == OWNER_WR) ? wr_ddr_len_i  : rd_ddr_len_i;
          addr_d       = (grant_owner == OWNER_WR) ? wr_ddr_addr_i : rd_ddr_addr_i;
        end
      end
      ST_GRANT: begin
        state_d = ST_BUSY;
        if (engine_strobe) mem_req_d = 1'b0;
      end
      ST_BUSY: begin
        if (engine_strobe) mem_req_d = 1'b0;
        if (mem_finish_i)  state_d   = ST_DONE;
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (timeout) begin
      state_d   = ST_IDLE;
      mem_req_d = 1'b0;
      err_d     = 1'b1;
    end
  end

  always_ff @(posedge ddr_clk_i) begin
    if (!ddr_rst_n_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_WR;
      last_owner_q <= OWNER_RD;
      mem_req_q    <= 1'b0;
      len_q        <= '0;
      addr_q       <= '0;
      wdog_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      mem_req_q    <= mem_req_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      wdog_q       <= wdog_d;
      err_q        <= err_d;
    end
  end

  assign mem_req_o         = mem_req_q;
  assign mem_rw_o          = (owner_q == OWNER_RD);
  assign mem_len_o         = len_q;
  assign mem_addr_o        = addr_q;
  assign arb_err_o         = err_q;

  assign wr_ddr_finish_o   = (state_q == ST_DONE) && (owner_q == OWNER_WR);
  assign rd_ddr_finish_o   = (state_q == ST_DONE) && (owner_q == OWNER_RD);

  assign ddr_fifo_rd_req_o = active && (owner_q == OWNER_WR) && mem_wr_data_rd_i;
  assign mem_wr_data_o     = wr_ddr_data_i;

  assign rd_ddr_data_vld_o = active && (owner_q == OWNER_RD) && mem_rd_data_vld_i;
  assign rd_ddr_data_o     = mem_rd_data_i;

endmodule

// File: tb/tb_mem_rw_arbiter.sv
// Directed bench for mem_rw_arbiter: default-timeout instance plus a 64-cycle-timeout instance.
module tb_mem_rw_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 256;

  logic          clk;
  logic          rst_n;
  logic          wr_req, rd_req;
  logic [7:0]    wr_len, rd_len;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [17:0]   wr_line, rd_line;

  logic          fifo_rd, wr_fin, rd_fin, rd_vld, err;
  logic [DW-1:0] rd_data;

  logic          to_fifo_rd, to_wr_fin, to_rd_fin, to_rd_vld, to_err;
  logic          to_req, to_rw;
  logic [7:0]    to_len;
  logic [AW-1:0] to_addr;
  logic [DW-1:0] to_rd_data, to_wr_data;

  int n_checks;
  int n_errors;
  int wr_fin_cnt, rd_fin_cnt, to_fin_cnt;
  int saved;

  mem_rw_arbiter_if #(.ADDR_WIDTH(AW), .MEM_DATA_BITS(DW)) mem_if ();

  mem_rw_arbiter #(.ADDR_WIDTH(AW), .MEM_DATA_BITS(DW)) dut (
    .ddr_clk_i(clk), .ddr_rst_n_i(rst_n),
    .wr_ddr_req_i(wr_req), .wr_ddr_len_i(wr_len), .wr_ddr_addr_i(wr_addr),
    .wr_ddr_data_i(wr_data), .ddr_fifo_rd_req_o(fifo_rd), .wr_ddr_finish_o(wr_fin),
    .rd_ddr_req_i(rd_req), .rd_ddr_len_i(rd_len), .rd_ddr_addr_i(rd_addr),
    .rd_ddr_data_o(rd_data), .rd_ddr_data_vld_o(rd_vld), .rd_ddr_finish_o(rd_fin),
    .wr_burst_line_i(wr_line), .rd_burst_line_i(rd_line),
    .mem_req_o(mem_if.mem_req), .mem_rw_o(mem_if.mem_rw), .mem_len_o(mem_if.mem_len),
    .mem_addr_o(mem_if.mem_addr), .mem_wr_data_rd_i(mem_if.mem_wr_data_rd),
    .mem_wr_data_o(mem_if.mem_wr_data), .mem_rd_data_i(mem_if.mem_rd_data),
    .mem_rd_data_vld_i(mem_if.mem_rd_data_vld), .mem_finish_i(mem_if.mem_finish),
    .arb_err_o(err)
  );

  mem_rw_arbiter #(.ADDR_WIDTH(AW), .MEM_DATA_BITS(DW), .TIMEOUT_CYCLES(64)) dut_to (
    .ddr_clk_i(clk), .ddr_rst_n_i(rst_n),
    .wr_ddr_req_i(wr_req), .wr_ddr_len_i(wr_len), .wr_ddr_addr_i(wr_addr),
    .wr_ddr_data_i(wr_data), .ddr_fifo_rd_req_o(to_fifo_rd), .wr_ddr_finish_o(to_wr_fin),
    .rd_ddr_req_i(rd_req), .rd_ddr_len_i(rd_len), .rd_ddr_addr_i(rd_addr),
    .rd_ddr_data_o(to_rd_data), .rd_ddr_data_vld_o(to_rd_vld), .rd_ddr_finish_o(to_rd_fin),
    .wr_burst_line_i(wr_line), .rd_burst_line_i(rd_line),
    .mem_req_o(to_req), .mem_rw_o(to_rw), .mem_len_o(to_len),
    .mem_addr_o(to_addr), .mem_wr_data_rd_i(mem_if.mem_wr_data_rd),
    .mem_wr_data_o(to_wr_data), .mem_rd_data_i(mem_if.mem_rd_data),
    .mem_rd_data_vld_i(mem_if.mem_rd_data_vld), .mem_finish_i(mem_if.mem_finish),
    .arb_err_o(to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_fin) wr_fin_cnt++;
    if (rd_fin) rd_fin_cnt++;
    if (to_wr_fin || to_rd_fin) to_fin_cnt++;
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    wr_fin_cnt = 0; rd_fin_cnt = 0; to_fin_cnt = 0;
    rst_n = 1'b0;
    wr_req = 0; rd_req = 0; wr_len = '0; rd_len = '0; wr_addr = '0; rd_addr = '0;
    wr_data = {8{32'hDEAD_BEEF}}; wr_line = '0; rd_line = '0;
    mem_if.mem_wr_data_rd = 0; mem_if.mem_rd_data_vld = 0; mem_if.mem_finish = 0;
    mem_if.mem_rd_data = '0;

    // Reset values
    tick(3);
    chk("rst_req",  mem_if.mem_req,  0);
    chk("rst_rw",   mem_if.mem_rw,   0);
    chk("rst_len",  mem_if.mem_len,  0);
    chk("rst_addr", mem_if.mem_addr, 0);
    chk("rst_err",  err,             0);
    chk("rst_wfin", wr_fin,          0);
    chk("rst_rfin", rd_fin,          0);
    rst_n = 1'b1;
    tick();

    // Write-only burst, len 128 at 0x400, finish 140 cycles after grant
    wr_req = 1; wr_len = 8'd128; wr_addr = 30'h400;
    tick();
    chk("t1_req",  mem_if.mem_req,  1);
    chk("t1_rw",   mem_if.mem_rw,   0);
    chk("t1_len",  mem_if.mem_len,  128);
    chk("t1_addr", mem_if.mem_addr, 30'h400);
    chk("t1_wdat", mem_if.mem_wr_data, {8{32'hDEAD_BEEF}});
    wr_req = 0; wr_len = '0; wr_addr = '0;
    mem_if.mem_wr_data_rd = 1;
    #1;
    chk("t1_fifo_rd", fifo_rd, 1);
    tick();
    mem_if.mem_wr_data_rd = 0;
    #1;
    chk("t1_req_drop", mem_if.mem_req, 0);
    chk("t1_len_hold", mem_if.mem_len, 128);
    chk("t1_fifo_idle", fifo_rd, 0);
    tick(138);
    mem_if.mem_finish = 1;
    chk("t1_wfin_pre", wr_fin, 0);
    tick();
    mem_if.mem_finish = 0;
    chk("t1_wfin", wr_fin, 1);
    chk("t1_rfin", rd_fin, 0);
    tick();
    chk("t1_wfin_end", wr_fin, 0);
    tick(2);
    chk("t1_wfin_cnt", wr_fin_cnt, 1);

    // Contested request from reset: WR first, RD after a one-cycle gap
    do_reset();
    wr_line = 18'd3; rd_line = 18'd0;
    wr_req = 1; wr_len = 8'd8;  wr_addr = 30'h100;
    rd_req = 1; rd_len = 8'd16; rd_addr = 30'h200;
    tick();
    chk("t2_w_rw",   mem_if.mem_rw,   0);
    chk("t2_w_len",  mem_if.mem_len,  8);
    chk("t2_w_addr", mem_if.mem_addr, 30'h100);
    tick();
    mem_if.mem_finish = 1;
    tick();
    mem_if.mem_finish = 0;
    chk("t2_wfin", wr_fin, 1);
    tick();
    chk("t2_gap_req", mem_if.mem_req, 0);
    chk("t2_gap_wfin", wr_fin, 0);
    tick();
    chk("t2_r_req",  mem_if.mem_req,  1);
    chk("t2_r_rw",   mem_if.mem_rw,   1);
    chk("t2_r_len",  mem_if.mem_len,  16);
    chk("t2_r_addr", mem_if.mem_addr, 30'h200);
    wr_req = 0; rd_req = 0;
    tick();
    // Write strobe during a read burst must not reach the write FIFO
    mem_if.mem_wr_data_rd = 1; mem_if.mem_rd_data_vld = 1;
    mem_if.mem_rd_data = {8{32'h1234_5678}};
    #1;
    chk("t2_fifo_rd_blk", fifo_rd, 0);
    chk("t2_rd_vld",  rd_vld,  1);
    chk("t2_rd_data", rd_data, {8{32'h1234_5678}});
    tick();
    mem_if.mem_wr_data_rd = 0; mem_if.mem_rd_data_vld = 0;
    mem_if.mem_finish = 1;
    tick();
    mem_if.mem_finish = 0;
    chk("t2_rfin", rd_fin, 1);
    chk("t2_wfin_r", wr_fin, 0);
    tick(2);

    // Read blocked on equal line counters, released when they differ
    wr_line = 18'd5; rd_line = 18'd5; rd_req = 1;
    tick(3);
    chk("t3_blocked", mem_if.mem_req, 0);
    wr_line = 18'd6;
    tick();
    chk("t3_req", mem_if.mem_req, 1);
    chk("t3_rw",  mem_if.mem_rw,  1);
    rd_req = 0;
    tick();
    mem_if.mem_finish = 1;
    tick();
    mem_if.mem_finish = 0;
    chk("t3_rfin", rd_fin, 1);
    tick(2);
    // Counters differing only in bit 17 are not equal
    rd_line = 18'h00005; wr_line = 18'h20005; rd_req = 1; rd_addr = 30'h3C0;
    tick();
    chk("t3_wrap_req",  mem_if.mem_req,  1);
    chk("t3_wrap_addr", mem_if.mem_addr, 30'h3C0);
    rd_req = 0;
    tick();

    // Reset during BUSY, then late engine strobes
    saved = rd_fin_cnt;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t4_req",  mem_if.mem_req,  0);
    chk("t4_rw",   mem_if.mem_rw,   0);
    chk("t4_len",  mem_if.mem_len,  0);
    chk("t4_addr", mem_if.mem_addr, 0);
    chk("t4_err",  err,             0);
    mem_if.mem_finish = 1; mem_if.mem_wr_data_rd = 1; mem_if.mem_rd_data_vld = 1;
    #1;
    chk("t4_fifo_rd", fifo_rd, 0);
    chk("t4_rd_vld",  rd_vld,  0);
    tick();
    mem_if.mem_finish = 0; mem_if.mem_wr_data_rd = 0; mem_if.mem_rd_data_vld = 0;
    chk("t4_rfin", rd_fin, 0);
    chk("t4_wfin", wr_fin, 0);
    tick(2);
    chk("t4_rfin_cnt", rd_fin_cnt, saved);

    // Watchdog on the 64-cycle instance
    do_reset();
    saved = to_fin_cnt;
    wr_req = 1; wr_addr = 30'h80; wr_len = 8'd4;
    tick();
    wr_req = 0;
    chk("t5_req",   to_req, 1);
    chk("t5_err0",  to_err, 0);
    tick(62);
    chk("t5_err62", to_err, 0);
    chk("t5_req62", to_req, 1);
    tick();
    chk("t5_err63", to_err, 1);
    chk("t5_req63", to_req, 0);
    tick(3);
    chk("t5_sticky", to_err, 1);
    chk("t5_nofin", to_fin_cnt, saved);
    wr_req = 1;
    tick();
    wr_req = 0;
    chk("t5_regrant", to_req, 1);

    do_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
